// File: rtl/if_stage_reg_pkg.sv
// Shared core constants for the pipeline registers of the 5-stage ARM core.
// The IF/ID, ID/EXE, EXE/MEM and MEM/WB registers all reuse these widths and constants.
package if_stage_reg_pkg;
    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;
    localparam logic [ADDR_W_DEF-1:0]  PC_STEP   = 32'd4;
endpackage

// File: rtl/if_stage_reg_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port, IF/ID contents and event counters out.
interface if_stage_reg_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               freeze;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_addr;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [ADDR_W-1:0]  if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic               if_id_valid;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output freeze, branch_taken, branch_addr, imem_rdata,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, branch_taken, branch_addr, imem_rdata,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/if_stage_reg.sv
// Fetch stage and IF/ID pipeline register: PC, instruction fetch, freeze on hazard,
// redirect-and-flush on taken branch, plus saturating stall/flush event counters.
module if_stage_reg
    import if_stage_reg_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_reg_if.slave bus
);
    logic [ADDR_W-1:0]  pc_q,          pc_d;
    logic [ADDR_W-1:0]  if_id_pc_q,    if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [ADDR_W-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

    // A taken branch is older than the stalled instruction, so it beats freeze.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (bus.branch_taken) begin
            pc_d          = bus.branch_addr;
            if_id_pc_d    = '0;
            if_id_instr_d = INSTR_W'(NOP_INSTR);
            if_id_valid_d = 1'b0;
        end else if (!bus.freeze) begin
            pc_d          = pc_plus4;
            if_id_pc_d    = pc_plus4;
            if_id_instr_d = bus.imem_rdata;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= INSTR_W'(NOP_INSTR);
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Index 0 counts stall cycles, index 1 counts flush cycles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = bus.freeze & ~bus.branch_taken;
    assign cnt_inc[1] = bus.branch_taken;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk    (clk),
                .clr_ni (rst),
                .inc_i  (cnt_inc[gi]),
                .cnt_o  (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.stall_cnt   = cnt_val[0];
    assign bus.flush_cnt   = cnt_val[1];
endmodule

// File: tb/tb_if_stage_reg.sv
// Scoreboard bench for if_stage_reg: a stimulus process pushes expected post-edge state,
// a monitor pops and compares it after every rising edge.
module tb_if_stage_reg;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    if_stage_reg_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(CNT_W)) bus ();

    if_stage_reg #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: every word encodes its own address.
    assign bus.imem_rdata = 32'hE000_0000 | bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imem_addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        int          stall;
        int          flush;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    // Reference state: the fetch address plus what the decode stage currently sees.
    logic [31:0] m_fetch;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifinstr;
    logic        m_valid;
    int          m_stall;
    int          m_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL txn=%0d %s got=%h want=%h", txn, name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.freeze       = f;
        bus.branch_taken = b;
        bus.branch_addr  = a;
        if (!r) begin
            m_fetch = 32'h0; m_ifpc = 32'h0; m_ifinstr = 32'h0; m_valid = 1'b0;
            m_stall = 0; m_flush = 0;
        end else if (b) begin
            m_fetch = a; m_ifpc = 32'h0; m_ifinstr = 32'h0; m_valid = 1'b0;
            m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        end else if (f) begin
            m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        end else begin
            m_ifinstr = 32'hE000_0000 | m_fetch;
            m_fetch   = m_fetch + 32'd4;
            m_ifpc    = m_fetch;
            m_valid   = 1'b1;
        end
        e.imem_addr = m_fetch; e.pc = m_ifpc; e.instr = m_ifinstr; e.valid = m_valid;
        e.stall = m_stall; e.flush = m_flush;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                txn++;
                chk("imem_addr",   bus.imem_addr,          e.imem_addr);
                chk("if_id_pc",    bus.if_id_pc,           e.pc);
                chk("if_id_instr", bus.if_id_instr,        e.instr);
                chk("if_id_valid", 32'(bus.if_id_valid),   32'(e.valid));
                chk("stall_cnt",   32'(bus.stall_cnt),     32'(e.stall));
                chk("flush_cnt",   32'(bus.flush_cnt),     32'(e.flush));
                $display("txn %0d: addr=%h pc=%h instr=%h v=%0d stall=%0d flush=%0d",
                         txn, bus.imem_addr, bus.if_id_pc, bus.if_id_instr,
                         bus.if_id_valid, bus.stall_cnt, bus.flush_cnt);
            end
        end
    end

    initial begin
        rst = 1'b0; bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'h0;
        m_fetch = 0; m_ifpc = 0; m_ifinstr = 0; m_valid = 0; m_stall = 0; m_flush = 0;

        step(0, 0, 0, 32'h0);
        step(0, 1, 1, 32'h1234);               // reset beats branch and freeze
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0);   // fetch 0,4,8,C
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0);   // freeze at PC=0x10
        step(1, 0, 0, 32'h0);                  // release
        step(1, 1, 1, 32'h200);                // branch wins over freeze
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h300);                // back-to-back branches
        step(1, 0, 1, 32'h403);                // unaligned target passes through
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'hFFFF_FFFC);          // wrap
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 32'h0);  // stall saturation
        step(0, 1, 0, 32'h0);                  // mid-stall reset
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic        r, f, b;
            logic [31:0] a;
            r = ($urandom_range(0, 49) != 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 6) == 0);
            a = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            step(r, f, b, a);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage_reg.md
Name: if_stage_reg

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage ARM core; directly upstream of the decode stage that drives hazard detection.
- Holds the PC, presents the fetch address to instruction memory, and latches {PC+4, instruction, valid} into IF/ID.
- Consumes the hazard detector's stall as a freeze, and the EXE-stage branch-taken as redirect plus flush.
- Keeps saturating stall/flush event counters for bring-up visibility.

Parameters:
- ADDR_W, 32, PC and instruction-address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded at reset.
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset; 0 at a rising clk edge resets all state
- freeze  in  1  hazard_detected from hazard detection; hold PC and IF/ID
- branch_taken  in  1  redirect from EXE; load branch_addr and flush IF/ID
- branch_addr  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  fetch address, equals current PC (combinational from PC register)
- imem_rdata  in  INSTR_W  instruction at imem_addr, combinational same-cycle read
- if_id_pc  out  ADDR_W  registered PC+4 of the latched instruction
- if_id_instr  out  INSTR_W  registered instruction
- if_id_valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble
- stall_cnt  out  CNT_W  cycles with freeze=1 and branch_taken=0, saturating
- flush_cnt  out  CNT_W  cycles with branch_taken=1, saturating

Behaviour:
- Reset at any edge where rst=0, including mid-stall or mid-branch:
  - pc=RESET_PC, if_id_pc=0, if_id_instr=0, if_id_valid=0, stall_cnt=0, flush_cnt=0.
  - Reset overrides all other inputs.
- First fetch: imem_addr=RESET_PC during the cycle after reset deasserts; that instruction appears in IF/ID one edge later.
- Per-edge priority with rst=1:
  - 1. branch_taken=1:
    - pc <= branch_addr.
    - IF/ID <= {0, 0, valid=0}, i.e. flushed.
    - Takes priority over freeze, because the branch is older than the stalled instruction.
  - 2. freeze=1 and branch_taken=0: pc and all IF/ID fields hold their values.
  - 3. Otherwise:
    - pc <= pc+4.
    - if_id_pc <= pc+4, if_id_instr <= imem_rdata, if_id_valid <= 1.
- PC arithmetic:
  - Modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0 with no flag.
  - branch_addr is used as-is, with no alignment check; low bits are passed through.
- Latency: instruction fetched at PC=A is visible on if_id_instr exactly one edge later unless frozen or flushed.
- Freeze duration is unbounded. On release, the held instruction stays in IF/ID for the release cycle, then advances normally. No instruction is lost or duplicated.
- Counters:
  - stall_cnt increments on each non-reset edge where freeze=1 and branch_taken=0.
  - flush_cnt increments on each non-reset edge where branch_taken=1.
  - Both saturate at 2^CNT_W-1.
- Back-to-back branches: each branch loads its own target; IF/ID stays a bubble for every branch cycle.
- No internal FSM beyond the PC and register state. Outputs are pure registers except imem_addr.

Decomposition:
- Shared core package holds:
  - NOP_INSTR (all zeros) and PC_STEP (4) constants.
  - Address/instruction width constants, reused by the ID/EXE, EXE/MEM and MEM/WB registers.
- One natural sub-module, sat_counter (width parameter, inc, synchronous active-low clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset then free run, with imem returning 0xE0000000|addr:
  - After reset release, imem_addr steps 0,4,8,C.
  - if_id_pc steps 4,8,C and if_id_instr steps 0xE0000000, 0xE0000004, 0xE0000008 on successive edges.
  - if_id_valid=1 from the first fetch edge.
- Freeze for 3 cycles with PC=0x10:
  - imem_addr stays 0x10 and IF/ID holds {0x10, instr@0xC, 1}.
  - stall_cnt=3; after release, next IF/ID is {0x14, instr@0x10, 1}.
- branch_taken=1, branch_addr=0x200 with freeze=1 in the same cycle:
  - Next edge: PC=0x200, if_id_valid=0, if_id_instr=0.
  - flush_cnt=1, stall_cnt unchanged.
  - Following edge: if_id_pc=0x204.
- Wrap: branch to 0xFFFFFFFC, then run 2 cycles -> imem_addr 0xFFFFFFFC then 0x00000000; if_id_pc=0x00000000 after the first fetch.
- Counter saturation: CNT_W=4, hold freeze for 20 cycles -> stall_cnt stops at 15.
- Mid-stall reset: freeze=1, rst=0 for one edge -> all outputs and counters at reset values; after release, fetch restarts at RESET_PC.
